// File: rtl/l2_req_rsp_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : l2_req_rsp_buffer_pkg
// Description : Field widths and packed payload widths of the L2 request and
//               response channels between the cluster arbiter and the L2.
//               Request  = {opcode,size,source,address,mask,data,param}
//               Response = {opcode,size,source,address,data,param}
// Revision    : 1.0  initial release
// ============================================================================
package l2_req_rsp_buffer_pkg;

  localparam int L2_OP_W     = 3;
  localparam int L2_SIZE_W   = 3;
  localparam int L2_SOURCE_W = 4;
  localparam int L2_ADDR_W   = 32;
  localparam int L2_MASK_W   = 4;
  localparam int L2_DATA_W   = 32;
  localparam int L2_PARAM_W  = 3;

  localparam int L2_REQ_W = L2_OP_W + L2_SIZE_W + L2_SOURCE_W + L2_ADDR_W +
                            L2_MASK_W + L2_DATA_W + L2_PARAM_W;
  localparam int L2_RSP_W = L2_OP_W + L2_SIZE_W + L2_SOURCE_W + L2_ADDR_W +
                            L2_DATA_W + L2_PARAM_W;

endpackage : l2_req_rsp_buffer_pkg
`default_nettype wire

// File: rtl/l2_buf_fifo.sv
`default_nettype none
// ============================================================================
// Module      : l2_buf_fifo
// Description : Registered synchronous FIFO with push/pop handshake. Read data
//               comes straight from the storage array, so an entry written in
//               cycle t appears on o_pop_data in cycle t+1. DEPTH need not be a
//               power of two; pointers wrap explicitly from DEPTH-1 to 0.
// Ports       : clk, rst         clock, synchronous active-high reset
//               i_push/i_push_data  write strobe and payload (ignored if full)
//               i_pop             read strobe (ignored if empty)
//               o_pop_data        head entry
//               o_full/o_empty    occupancy flags
//               o_count           number of stored entries
// Revision    : 1.0  initial release
// ============================================================================
module l2_buf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full     = (r_count == C_FULL_CNT);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop  && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset: contents are only observable through the
  // pointers, which are reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

endmodule : l2_buf_fifo
`default_nettype wire

// File: rtl/l2_req_rsp_buffer.sv
`default_nettype none
// ============================================================================
// Module      : l2_req_rsp_buffer
// Description : Registered decoupling stage between the cluster arbiter and
//               the L2. Requests pass through a request FIFO; L2 responses are
//               buffered in a response FIFO. Issue to L2 is held off once
//               RSP_DEPTH requests are outstanding, so every response the L2
//               can legally return already has a response slot reserved.
// Ports       : clk, rst                        clock, sync active-high reset
//               req_in_*  (valid/ready/bits)     from arbiter
//               req_out_* (valid/ready/bits)     to L2
//               rsp_in_*  (valid/ready/bits)     from L2
//               rsp_out_* (valid/ready/bits)     to arbiter
//               outstanding_o                    issued, not yet delivered
// Revision    : 1.0  initial release
// ============================================================================
module l2_req_rsp_buffer
  import l2_req_rsp_buffer_pkg::*;
#(
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_in_valid,
  output logic                           req_in_ready,
  input  logic [L2_REQ_W-1:0]            req_in_bits,
  output logic                           req_out_valid,
  input  logic                           req_out_ready,
  output logic [L2_REQ_W-1:0]            req_out_bits,
  input  logic                           rsp_in_valid,
  output logic                           rsp_in_ready,
  input  logic [L2_RSP_W-1:0]            rsp_in_bits,
  output logic                           rsp_out_valid,
  input  logic                           rsp_out_ready,
  output logic [L2_RSP_W-1:0]            rsp_out_bits,
  output logic [$clog2(RSP_DEPTH+1)-1:0] outstanding_o
);

  localparam int OUT_W     = $clog2(RSP_DEPTH+1);
  localparam int REQ_CNT_W = $clog2(REQ_DEPTH+1);
  localparam logic [OUT_W-1:0]     C_MAX_OUT = OUT_W'(RSP_DEPTH);
  localparam logic [REQ_CNT_W-1:0] C_REQ_MAX = REQ_CNT_W'(REQ_DEPTH);

  logic                 w_req_full;
  logic                 w_req_empty;
  logic [REQ_CNT_W-1:0] w_req_count;
  logic                 w_rsp_full;
  logic                 w_rsp_empty;
  logic [OUT_W-1:0]     w_rsp_count;

  logic w_req_push;
  logic w_req_pop;
  logic w_rsp_push;
  logic w_rsp_pop;

  logic [OUT_W-1:0] r_outstanding;

  // Readies and valids are forced low while rst is high so nothing is
  // accepted or presented during the reset cycle itself.
  assign req_in_ready  = !rst && !w_req_full;
  assign req_out_valid = !rst && !w_req_empty && (r_outstanding < C_MAX_OUT);
  assign rsp_in_ready  = !rst && !w_rsp_full;
  assign rsp_out_valid = !rst && !w_rsp_empty;

  assign w_req_push = req_in_valid  && req_in_ready;
  assign w_req_pop  = req_out_valid && req_out_ready;
  assign w_rsp_push = rsp_in_valid  && rsp_in_ready;
  assign w_rsp_pop  = rsp_out_valid && rsp_out_ready;

  assign outstanding_o = r_outstanding;

  l2_buf_fifo #(
    .WIDTH (L2_REQ_W),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_req_push),
    .i_push_data (req_in_bits),
    .i_pop       (w_req_pop),
    .o_pop_data  (req_out_bits),
    .o_full      (w_req_full),
    .o_empty     (w_req_empty),
    .o_count     (w_req_count)
  );

  l2_buf_fifo #(
    .WIDTH (L2_RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_rsp_push),
    .i_push_data (rsp_in_bits),
    .i_pop       (w_rsp_pop),
    .o_pop_data  (rsp_out_bits),
    .o_full      (w_rsp_full),
    .o_empty     (w_rsp_empty),
    .o_count     (w_rsp_count)
  );

  // Outstanding = issued to L2 but not yet handed back on rsp_out. The issue
  // gate stops increments at RSP_DEPTH; the decrement is guarded against a
  // stray rsp_out fire at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
    end else begin
      case ({w_req_pop, w_rsp_pop})
        2'b10: r_outstanding <= r_outstanding + OUT_W'(1);
        2'b01: begin
          if (r_outstanding != '0) begin
            r_outstanding <= r_outstanding - OUT_W'(1);
          end
        end
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  a_no_rsp_underflow: assert property (@(posedge clk) disable iff (rst)
    w_rsp_pop |-> (r_outstanding != '0));

  a_rsp_within_outstanding: assert property (@(posedge clk) disable iff (rst)
    w_rsp_count <= r_outstanding);

  a_req_count_bound: assert property (@(posedge clk) disable iff (rst)
    w_req_count <= C_REQ_MAX);

endmodule : l2_req_rsp_buffer
`default_nettype wire
